lcd_frame_sequencer: RTL and testbench

Sequences the character LCD for the digital clock. After reset it issues the HD44780 power-on command set, then writes one 9-byte frame per refresh: a home command followed by the ASCII time string "HH:MM:SS". It sits between the BCD time counters and the LCD byte interface. Bytes are passed to the interface over a valid/ready handshake.

---
 rtl/lcd_frame_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// HD44780 character LCD sequencer: issues the power-on command set, then streams
// one home command plus the "HH:MM:SS" time string per refresh over valid/ready.
module lcd_frame_sequencer #(
  parameter int unsigned CLEAR_WAIT = 100,
  parameter logic [7:0]  SEP_CHAR   = 8'h3A,
  parameter logic [7:0]  HOME_CMD   = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] time_bcd,
  input  logic        update,
  input  logic        lcd_ready,
  output logic        lcd_valid,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data,
  output logic        init_done,
  output logic        busy
);

  localparam int unsigned WAIT_W = (CLEAR_WAIT > 1) ? $clog2(CLEAR_WAIT) : 1;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned TIME_W = 24;

  localparam logic [IDX_W-1:0]  INIT_LAST  = IDX_W'(3);
  localparam logic [IDX_W-1:0]  FRAME_LAST = IDX_W'(8);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(CLEAR_WAIT - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_INIT_WAIT,
    S_IDLE,
    S_FRAME
  } state_t;

  // Power-on command set: function set, display on, entry mode, clear.
  function automatic logic [7:0] f_init_byte(input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      IDX_W'(0): b = 8'h38;
      IDX_W'(1): b = 8'h0C;
      IDX_W'(2): b = 8'h06;
      default:   b = 8'h01;
    endcase
    return b;
  endfunction

  // Non-decimal nibbles show as '?' so a corrupted counter is visible on the panel.
  function automatic logic [7:0] f_digit(input logic [3:0] nib);
    return (nib > 4'd9) ? 8'h3F : (8'h30 + {4'h0, nib});
  endfunction

  // Frame byte as {rs, data}: slot 0 is the home command, slots 1..8 the string.
  function automatic logic [8:0] f_frame_byte(input logic [IDX_W-1:0]  idx,
                                              input logic [TIME_W-1:0] t);
    logic [8:0] b;
    case (idx)
      IDX_W'(0): b = {1'b0, HOME_CMD};
      IDX_W'(1): b = {1'b1, f_digit(t[23:20])};
      IDX_W'(2): b = {1'b1, f_digit(t[19:16])};
      IDX_W'(3): b = {1'b1, SEP_CHAR};
      IDX_W'(4): b = {1'b1, f_digit(t[15:12])};
      IDX_W'(5): b = {1'b1, f_digit(t[11:8])};
      IDX_W'(6): b = {1'b1, SEP_CHAR};
      IDX_W'(7): b = {1'b1, f_digit(t[7:4])};
      default:   b = {1'b1, f_digit(t[3:0])};
    endcase
    return b;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic                r_pending;
  logic                w_pending_nxt;
  logic [TIME_W-1:0]   r_time;
  logic [TIME_W-1:0]   w_time_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_rs;
  logic                w_rs_nxt;
  logic [7:0]          r_data;
  logic [7:0]          w_data_nxt;
  logic                r_init_done;
  logic                w_init_done_nxt;
  logic                r_busy;
  logic                w_busy_nxt;

  logic                w_xfer;
  logic                w_req;
  logic                w_start;
  logic [8:0]          w_next_byte;

  assign w_xfer      = r_valid & lcd_ready;
  assign w_req       = r_pending | update;
  assign w_next_byte = f_frame_byte(r_idx + IDX_W'(1), r_time);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_idx       <= '0;
      r_wait      <= '0;
      r_pending   <= 1'b1;
      r_time      <= '0;
      r_valid     <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_wait      <= w_wait_nxt;
      r_pending   <= w_pending_nxt;
      r_time      <= w_time_nxt;
      r_valid     <= w_valid_nxt;
      r_rs        <= w_rs_nxt;
      r_data      <= w_data_nxt;
      r_init_done <= w_init_done_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and output decode; unchanged fields hold, which keeps data stable under backpressure.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_wait_nxt      = r_wait;
    w_pending_nxt   = r_pending;
    w_time_nxt      = r_time;
    w_valid_nxt     = r_valid;
    w_rs_nxt        = r_rs;
    w_data_nxt      = r_data;
    w_init_done_nxt = r_init_done;
    w_busy_nxt      = r_busy;
    w_start         = 1'b0;

    case (r_state)
      S_INIT: begin
        w_pending_nxt = w_req;
        w_busy_nxt    = 1'b1;
        if (!r_valid) begin
          w_valid_nxt = 1'b1;
          w_rs_nxt    = 1'b0;
          w_data_nxt  = f_init_byte(r_idx);
        end else if (w_xfer) begin
          if (r_idx == INIT_LAST) begin
            w_state_nxt = S_INIT_WAIT;
            w_valid_nxt = 1'b0;
            w_idx_nxt   = '0;
            w_wait_nxt  = '0;
          end else begin
            w_idx_nxt  = r_idx + IDX_W'(1);
            w_data_nxt = f_init_byte(r_idx + IDX_W'(1));
          end
        end
      end

      S_INIT_WAIT: begin
        w_pending_nxt = w_req;
        if (r_wait == WAIT_LAST) begin
          w_state_nxt     = S_IDLE;
          w_init_done_nxt = 1'b1;
          w_busy_nxt      = 1'b0;
          w_wait_nxt      = '0;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end

      S_IDLE: begin
        w_busy_nxt = 1'b0;
        w_start    = w_req;
      end

      S_FRAME: begin
        w_pending_nxt = w_req;
        if (!r_valid) begin
          // Gap cycle after a frame that left a refresh pending.
          w_start = 1'b1;
        end else if (w_xfer) begin
          if (r_idx == FRAME_LAST) begin
            w_valid_nxt = 1'b0;
            w_idx_nxt   = '0;
            if (!w_req) begin
              w_state_nxt = S_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_idx_nxt  = r_idx + IDX_W'(1);
            w_rs_nxt   = w_next_byte[8];
            w_data_nxt = w_next_byte[7:0];
          end
        end
      end

      default: begin
        w_state_nxt = S_INIT;
      end
    endcase

    // Frame start: snapshot the time and consume any pending/coincident update.
    if (w_start) begin
      w_state_nxt   = S_FRAME;
      w_time_nxt    = time_bcd;
      w_pending_nxt = 1'b0;
      w_idx_nxt     = '0;
      w_valid_nxt   = 1'b1;
      w_rs_nxt      = 1'b0;
      w_data_nxt    = HOME_CMD;
      w_busy_nxt    = 1'b1;
    end
  end

  assign lcd_valid = r_valid;
  assign lcd_rs    = r_rs;
  assign lcd_data  = r_data;
  assign init_done = r_init_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer: a byte-stream model (expected queue) checked on
// every accepted byte, plus directed timing and literal checks.
module tb_lcd_frame_sequencer;

  localparam int CW = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] time_bcd = '0;
  logic        update = 1'b0;
  logic        lcd_ready = 1'b1;
  logic        lcd_valid;
  logic        lcd_rs;
  logic [7:0]  lcd_data;
  logic        init_done;
  logic        busy;

  lcd_frame_sequencer #(
    .CLEAR_WAIT (CW),
    .SEP_CHAR   (8'h3A),
    .HOME_CMD   (8'h80)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .time_bcd  (time_bcd),
    .update    (update),
    .lcd_ready (lcd_ready),
    .lcd_valid (lcd_valid),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .init_done (init_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  logic [8:0] log_byte[$];
  int         log_cyc[$];
  int         done_cyc = -1;
  logic       prev_stall = 1'b0;
  logic       prev_done  = 1'b0;
  logic [8:0] prev_byte  = '0;
  logic [8:0] mon_exp;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  // Model: expected frame as {rs,data} from the time digits.
  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n > 4'd9) ? 8'h3F : (8'h30 + {4'h0, n});
  endfunction

  task automatic push_frame(input logic [23:0] t);
    exp_q.push_back({1'b0, 8'h80});
    for (int k = 5; k >= 0; k--) begin
      exp_q.push_back({1'b1, asc(t[k*4 +: 4])});
      if (k == 4 || k == 2) exp_q.push_back({1'b1, 8'h3A});
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  // Every accepted byte is checked against the model; stalled bytes must hold.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
      prev_done  <= 1'b0;
      done_cyc   <= -1;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(lcd_valid), 1);
        chk("hold_byte", int'({lcd_rs, lcd_data}), int'(prev_byte));
      end
      if (lcd_valid && lcd_ready) begin
        log_byte.push_back({lcd_rs, lcd_data});
        log_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%0h expected none at cycle %0d",
                   {lcd_rs, lcd_data}, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("stream_byte", int'({lcd_rs, lcd_data}), int'(mon_exp));
        end
      end
      if (init_done && !prev_done) done_cyc <= cyc;
      prev_stall <= lcd_valid && !lcd_ready;
      prev_byte  <= {lcd_rs, lcd_data};
      prev_done  <= init_done;
    end
  end

  task automatic do_reset(input logic [23:0] t);
    rst = 1'b0;
    update = 1'b0;
    lcd_ready = 1'b1;
    time_bcd = t;
    exp_q.delete();
    log_byte.delete();
    log_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(lcd_valid), 0);
    chk("rst_rs", int'(lcd_rs), 0);
    chk("rst_data", int'(lcd_data), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    push_init();
    push_frame(t);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_byte", int'({lcd_valid, lcd_rs, lcd_data}), int'({1'b1, 1'b0, 8'h38}));
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(posedge clk);
    #1;
    update = 1'b0;
  endtask

  task automatic run(input int max_cyc, input logic [3:0] pat);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      lcd_ready = pat[2'(i)];
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    lcd_ready = 1'b1;
    chk("run_complete", int'(ok), 1);
  endtask

  task automatic settle_check(input int n_bytes);
    repeat (12) @(posedge clk);
    #1;
    chk("no_extra_frame", log_byte.size(), n_bytes);
    chk("idle_busy", int'(busy), 0);
  endtask

  logic [8:0] lit4[8];
  logic [8:0] lit2[8];
  bit found;

  initial begin
    lit2 = '{9'h132, 9'h133, 9'h13A, 9'h135, 9'h139, 9'h13A, 9'h135, 9'h139};
    lit4 = '{9'h131, 9'h13F, 9'h13A, 9'h130, 9'h13F, 9'h13A, 9'h130, 9'h130};

    // 1: power-on init, clear wait, automatic first frame
    do_reset(24'h000000);
    run(400, 4'hF);
    chk("t1_count", log_byte.size(), 13);
    if (log_byte.size() == 13) begin
      chk("t1_init_b2b", log_cyc[3] - log_cyc[0], 3);
      chk("t1_done_delay", done_cyc - log_cyc[3], CW + 1);
      chk("t1_home_delay", log_cyc[4] - log_cyc[3], CW + 2);
      chk("t1_home", int'(log_byte[4]), int'(9'h080));
      chk("t1_zero", int'(log_byte[5]), int'(9'h130));
      chk("t1_sep", int'(log_byte[7]), int'(9'h13A));
    end
    chk("t1_init_done", int'(init_done), 1);
    chk("t1_busy", int'(busy), 0);

    // 2: backpressure with ready 1-0-0-1
    log_byte.delete();
    log_cyc.delete();
    time_bcd = 24'h235959;
    push_frame(24'h235959);
    pulse_update();
    run(200, 4'b1001);
    chk("t2_count", log_byte.size(), 9);
    if (log_byte.size() == 9)
      for (int k = 0; k < 8; k++) chk("t2_digit", int'(log_byte[k+1]), int'(lit2[k]));

    // 3: snapshot held, updates collapse into one following frame
    log_byte.delete();
    log_cyc.delete();
    time_bcd = 24'h123456;
    push_frame(24'h123456);
    push_frame(24'h123457);
    pulse_update();
    repeat (3) @(posedge clk);
    #1;
    time_bcd = 24'h123457;
    pulse_update();
    @(posedge clk);
    #1;
    pulse_update();
    run(200, 4'hF);
    chk("t3_count", log_byte.size(), 18);
    if (log_byte.size() == 18) begin
      chk("t3_gap", log_cyc[9] - log_cyc[8], 2);
      chk("t3_s1_first", int'(log_byte[8]), int'(9'h136));
      chk("t3_s1_second", int'(log_byte[17]), int'(9'h137));
    end
    settle_check(18);

    // 4: non-decimal nibbles
    log_byte.delete();
    log_cyc.delete();
    time_bcd = 24'h1A0F00;
    push_frame(24'h1A0F00);
    pulse_update();
    run(200, 4'hF);
    chk("t4_count", log_byte.size(), 9);
    if (log_byte.size() == 9)
      for (int k = 0; k < 8; k++) chk("t4_digit", int'(log_byte[k+1]), int'(lit4[k]));

    // 5: reset while the 4th data byte is on the bus
    log_byte.delete();
    log_cyc.delete();
    time_bcd = 24'h112233;
    push_frame(24'h112233);
    pulse_update();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lcd_valid && lcd_rs && lcd_data == 8'h32) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_reached", int'(found), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_abort_valid", int'(lcd_valid), 0);
    chk("t5_abort_done", int'(init_done), 0);
    chk("t5_abort_busy", int'(busy), 1);
    do_reset(24'h112233);
    run(400, 4'hF);
    chk("t5_count", log_byte.size(), 13);
    if (log_byte.size() == 13) chk("t5_restart", int'(log_byte[0]), int'(9'h038));

    // 6: update during the clear wait yields one frame only
    do_reset(24'h000102);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (log_byte.size() == 4) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_init_sent", int'(found), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_in_wait", int'(init_done), 0);
    pulse_update();
    run(400, 4'hF);
    chk("t6_count", log_byte.size(), 13);
    settle_check(13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
